// File: rtl/lsu_unit_if.sv
// Handshake bundles for lsu_unit: execute-side request/response channel and
// data-memory beat channel.
interface lsu_req_if #(parameter int ADDR_W = 64, parameter int DATA_W = 64);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [3:0]        req_ctrl;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (output req_valid, req_addr, req_wdata, req_ctrl, rsp_ready,
                    input  req_ready, rsp_valid, rsp_rdata, rsp_err);
    modport slave  (input  req_valid, req_addr, req_wdata, req_ctrl, rsp_ready,
                    output req_ready, rsp_valid, rsp_rdata, rsp_err);
endinterface

interface lsu_mem_if #(parameter int ADDR_W = 64, parameter int DATA_W = 64);
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [ADDR_W-1:0]     mem_addr;
    logic                  mem_wen;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_wstrb;
    logic                  mem_rsp_valid;
    logic [DATA_W-1:0]     mem_rdata;
    logic                  mem_rsp_err;

    modport master (output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wstrb,
                    input  mem_req_ready, mem_rsp_valid, mem_rdata, mem_rsp_err);
    modport slave  (input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wstrb,
                    output mem_req_ready, mem_rsp_valid, mem_rdata, mem_rsp_err);
endinterface

// File: rtl/lsu_unit.sv
// Sequential load/store unit: one op in flight, 8-byte aligned memory beats.
// Define MISALIGN_TRAP_EN to fault misaligned accesses instead of aligning them down.
module lsu_unit #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input logic        clk,
    input logic        rst_n,
    lsu_req_if.slave   req,
    lsu_mem_if.master  mem
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    typedef struct packed {
        logic       legal;
        logic       store;
        logic       sext;
        logic [1:0] size;   // log2 of access bytes
    } op_t;

    function automatic op_t decode(input logic [3:0] c);
        op_t o;
        o = '{legal: 1'b1, store: c[3], sext: 1'b0, size: 2'd3};
        case (c)
            4'b0000: o.size = 2'd3;
            4'b0001: o.size = 2'd1;
            4'b0010: o.size = 2'd0;
            4'b0011: begin o.size = 2'd2; o.sext = 1'b1; end
            4'b0100: begin o.size = 2'd1; o.sext = 1'b1; end
            4'b0101: begin o.size = 2'd0; o.sext = 1'b1; end
            4'b0110: o.size = 2'd2;
            4'b1000: o.size = 2'd3;
            4'b1001: o.size = 2'd2;
            4'b1010: o.size = 2'd1;
            4'b1011: o.size = 2'd0;
            default: o.legal = 1'b0;
        endcase
        return o;
    endfunction

    state_t              state_q;
    logic                req_ready_q, rsp_valid_q, rsp_err_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic                mem_req_valid_q, mem_wen_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic [7:0]          mem_wstrb_q;
    logic [2:0]          off_q;
    logic [1:0]          size_q;
    logic                sext_q;

    op_t                 op_d;
    logic [2:0]          off_d;
    logic [7:0]          mask8;
    logic [DATA_W-1:0]   wmask, wdata_d, shifted, ld_data;
    logic [7:0]          wstrb_d;
    logic                trap_d;

    // Request-side decode: offset is aligned down to the access size.
    always_comb begin
        op_d  = decode(req.req_ctrl);
        off_d = req.req_addr[2:0] & (3'b111 << op_d.size);
        case (op_d.size)
            2'd0:    mask8 = 8'h01;
            2'd1:    mask8 = 8'h03;
            2'd2:    mask8 = 8'h0F;
            default: mask8 = 8'hFF;
        endcase
        for (int i = 0; i < 8; i++) wmask[8*i +: 8] = {8{mask8[i]}};
        wstrb_d = mask8 << off_d;
        wdata_d = (req.req_wdata & wmask) << {off_d, 3'b000};
`ifdef MISALIGN_TRAP_EN
        trap_d  = (req.req_addr[2:0] != off_d);
`else
        trap_d  = 1'b0;
`endif
    end

    // Response-side lane extraction and extension.
    always_comb begin
        shifted = mem.mem_rdata >> {off_q, 3'b000};
        case (size_q)
            2'd0:    ld_data = {{56{sext_q & shifted[7]}},  shifted[7:0]};
            2'd1:    ld_data = {{48{sext_q & shifted[15]}}, shifted[15:0]};
            2'd2:    ld_data = {{32{sext_q & shifted[31]}}, shifted[31:0]};
            default: ld_data = shifted;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            req_ready_q     <= 1'b1;
            rsp_valid_q     <= 1'b0;
            rsp_err_q       <= 1'b0;
            rsp_rdata_q     <= '0;
            mem_req_valid_q <= 1'b0;
            mem_wen_q       <= 1'b0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            mem_wstrb_q     <= '0;
            off_q           <= '0;
            size_q          <= '0;
            sext_q          <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (req.req_valid) begin
                    req_ready_q <= 1'b0;
                    off_q       <= off_d;
                    size_q      <= op_d.size;
                    sext_q      <= op_d.sext;
                    if (!op_d.legal || trap_d) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                    end else begin
                        state_q         <= REQ;
                        mem_req_valid_q <= 1'b1;
                        mem_addr_q      <= {req.req_addr[ADDR_W-1:3], 3'b000};
                        mem_wen_q       <= op_d.store;
                        mem_wdata_q     <= wdata_d;
                        mem_wstrb_q     <= wstrb_d;
                    end
                end
                REQ: if (mem.mem_req_ready) begin
                    state_q         <= WAIT;
                    mem_req_valid_q <= 1'b0;
                end
                WAIT: if (mem.mem_rsp_valid) begin
                    state_q     <= RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= mem.mem_rsp_err;
                    rsp_rdata_q <= (mem.mem_rsp_err || mem_wen_q) ? '0 : ld_data;
                end
                RESP: if (req.rsp_ready) begin
                    state_q     <= IDLE;
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req.req_ready     = req_ready_q;
    assign req.rsp_valid     = rsp_valid_q;
    assign req.rsp_rdata     = rsp_rdata_q;
    assign req.rsp_err       = rsp_err_q;
    assign mem.mem_req_valid = mem_req_valid_q;
    assign mem.mem_addr      = mem_addr_q;
    assign mem.mem_wen       = mem_wen_q;
    assign mem.mem_wdata     = mem_wdata_q;
    assign mem.mem_wstrb     = mem_wstrb_q;
endmodule

// File: tb/tb_lsu_unit.sv
// Self-checking bench for lsu_unit: directed scenarios plus randomized ops
// against an arithmetic reference model.
module tb_lsu_unit;
    logic clk, rst_n;
    int checks, errors;
`ifdef MISALIGN_TRAP_EN
    bit trap_en = 1'b1;
`else
    bit trap_en = 1'b0;
`endif

    lsu_req_if rq();
    lsu_mem_if mm();

    lsu_unit dut (.clk(clk), .rst_n(rst_n), .req(rq), .mem(mm));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model from the op table: byte count, alignment, extension.
    task automatic model(input logic [3:0] c, input logic [63:0] a, wd, rd, input bit merr,
                         output bit legal, output bit beat, output logic [63:0] e_addr,
                         output logic [63:0] e_wdata, output logic [7:0] e_strb,
                         output bit e_wen, output logic [63:0] e_rdata, output bit e_err);
        int sz, off, aoff;
        bit sx, trap;
        logic [63:0] mask, v;
        legal = 1'b1; sx = 1'b0; sz = 8;
        case (c)
            4'd0: sz = 8;            4'd1: sz = 2;            4'd2: sz = 1;
            4'd3: begin sz = 4; sx = 1'b1; end
            4'd4: begin sz = 2; sx = 1'b1; end
            4'd5: begin sz = 1; sx = 1'b1; end
            4'd6: sz = 4;
            4'd8: sz = 8;            4'd9: sz = 4;            4'd10: sz = 2;
            4'd11: sz = 1;
            default: legal = 1'b0;
        endcase
        off  = int'(a % 8);
        aoff = (off / sz) * sz;
        trap = legal && trap_en && (off % sz != 0);
        beat = legal && !trap;
        mask = (sz == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * sz)) - 64'd1);
        e_addr  = a - (a % 8);
        e_strb  = 8'(((1 << sz) - 1) << aoff);
        e_wdata = (wd & mask) << (8 * aoff);
        e_wen   = (c >= 4'd8);
        v = (rd >> (8 * aoff)) & mask;
        if (sx && v[8*sz-1]) v = v | ~mask;
        e_err   = !beat || merr;
        e_rdata = (e_err || e_wen) ? 64'd0 : v;
    endtask

    // One full transaction; starts and ends on a negedge with the unit idle.
    task automatic run_op(input string tag, input logic [3:0] c, input logic [63:0] a, wd, rd,
                          input int mrdy_dly, input int mrsp_dly, input int rrdy_dly, input bit merr);
        bit legal, beat, e_wen, e_err;
        logic [63:0] e_addr, e_wdata, e_rdata;
        logic [7:0] e_strb;
        model(c, a, wd, rd, merr, legal, beat, e_addr, e_wdata, e_strb, e_wen, e_rdata, e_err);
        checks++; if (rq.req_ready !== 1'b1) begin errors++; $display("FAIL %s req_ready_idle got %b want 1", tag, rq.req_ready); end
        rq.req_valid = 1'b1; rq.req_ctrl = c; rq.req_addr = a; rq.req_wdata = wd;
        @(negedge clk);
        rq.req_valid = 1'b0; rq.req_ctrl = 4'hF; rq.req_addr = '1; rq.req_wdata = '1;
        checks++; if (rq.req_ready !== 1'b0) begin errors++; $display("FAIL %s req_ready_busy got %b want 0", tag, rq.req_ready); end
        if (!beat) begin
            checks++; if (mm.mem_req_valid !== 1'b0) begin errors++; $display("FAIL %s no_beat got mem_req_valid=%b want 0", tag, mm.mem_req_valid); end
        end else begin
            for (int i = 0; i <= mrdy_dly; i++) begin
                checks++;
                if (mm.mem_req_valid !== 1'b1 || mm.mem_addr !== e_addr || mm.mem_wen !== e_wen ||
                    mm.mem_wdata !== e_wdata || mm.mem_wstrb !== e_strb) begin
                    errors++;
                    $display("FAIL %s beat[%0d] got v=%b a=%h w=%b d=%h s=%h want v=1 a=%h w=%b d=%h s=%h", tag, i,
                             mm.mem_req_valid, mm.mem_addr, mm.mem_wen, mm.mem_wdata, mm.mem_wstrb,
                             e_addr, e_wen, e_wdata, e_strb);
                end
                if (i == mrdy_dly) mm.mem_req_ready = 1'b1;
                @(negedge clk);
            end
            mm.mem_req_ready = 1'b0;
            checks++; if (mm.mem_req_valid !== 1'b0) begin errors++; $display("FAIL %s beat_drop got %b want 0", tag, mm.mem_req_valid); end
            for (int i = 0; i < mrsp_dly; i++) @(negedge clk);
            checks++; if (rq.rsp_valid !== 1'b0) begin errors++; $display("FAIL %s early_rsp got %b want 0", tag, rq.rsp_valid); end
            mm.mem_rsp_valid = 1'b1; mm.mem_rdata = rd; mm.mem_rsp_err = merr;
            @(negedge clk);
            mm.mem_rsp_valid = 1'b0; mm.mem_rdata = '0; mm.mem_rsp_err = 1'b0;
        end
        for (int i = 0; i <= rrdy_dly; i++) begin
            checks++;
            if (rq.rsp_valid !== 1'b1 || rq.rsp_rdata !== e_rdata || rq.rsp_err !== e_err || rq.req_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s rsp[%0d] got v=%b d=%h e=%b rdy=%b want v=1 d=%h e=%b rdy=0", tag, i,
                         rq.rsp_valid, rq.rsp_rdata, rq.rsp_err, rq.req_ready, e_rdata, e_err);
            end
            if (i == rrdy_dly) rq.rsp_ready = 1'b1;
            @(negedge clk);
        end
        rq.rsp_ready = 1'b0;
        checks++;
        if (rq.rsp_valid !== 1'b0 || rq.req_ready !== 1'b1) begin
            errors++; $display("FAIL %s rsp_done got v=%b rdy=%b want v=0 rdy=1", tag, rq.rsp_valid, rq.req_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (rq.req_ready !== 1'b1 || rq.rsp_valid !== 1'b0 || rq.rsp_err !== 1'b0 || rq.rsp_rdata !== 64'd0 ||
            mm.mem_req_valid !== 1'b0 || mm.mem_wen !== 1'b0 || mm.mem_wstrb !== 8'd0 ||
            mm.mem_addr !== 64'd0 || mm.mem_wdata !== 64'd0) begin
            errors++;
            $display("FAIL reset got rdy=%b rv=%b re=%b rd=%h mv=%b wen=%b s=%h a=%h d=%h want 1,0,0,0,0,0,0,0,0",
                     rq.req_ready, rq.rsp_valid, rq.rsp_err, rq.rsp_rdata, mm.mem_req_valid, mm.mem_wen,
                     mm.mem_wstrb, mm.mem_addr, mm.mem_wdata);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_store_sb();
        run_op("sb", 4'b1011, 64'h8000_0005, 64'h1234_56AB, 64'h0, 0, 0, 0, 1'b0);
    endtask

    task automatic test_load_lw();
        run_op("lw", 4'b0011, 64'h8000_0004, 64'h0, 64'h8000_0001_0000_0000, 0, 0, 0, 1'b0);
    endtask

    task automatic test_byte_ext();
        run_op("lbu_off7", 4'b0010, 64'h1000_0007, 64'h0, 64'hF012_3456_789A_BCDE, 0, 1, 0, 1'b0);
        run_op("lb_off7",  4'b0101, 64'h1000_0007, 64'h0, 64'hF012_3456_789A_BCDE, 0, 1, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_op("bp_sd", 4'b1000, 64'h2000_0010, 64'hDEAD_BEEF_CAFE_F00D, 64'h0, 3, 0, 2, 1'b0);
        run_op("bp_ld", 4'b0000, 64'h2000_0018, 64'h0, 64'h0123_4567_89AB_CDEF, 3, 2, 2, 1'b0);
    endtask

    task automatic test_illegal_misalign();
        run_op("illegal", 4'b1111, 64'h3000_0000, 64'h0, 64'h0, 0, 0, 0, 1'b0);
        run_op("lh_addr3", 4'b0100, 64'h0000_0003, 64'h0, 64'h1122_3344_8877_6655, 0, 0, 0, 1'b0);
    endtask

    task automatic test_mem_err();
        run_op("mem_err", 4'b0000, 64'h4000_0000, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1, 1, 1'b1);
    endtask

    task automatic test_reset_mid();
        rq.req_valid = 1'b1; rq.req_ctrl = 4'b0011; rq.req_addr = 64'h5000_0000; rq.req_wdata = '0;
        @(negedge clk);
        rq.req_valid = 1'b0;
        mm.mem_req_ready = 1'b1;
        @(negedge clk);
        mm.mem_req_ready = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mm.mem_rsp_valid = 1'b1; mm.mem_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
        @(negedge clk);
        mm.mem_rsp_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (rq.rsp_valid !== 1'b0 || rq.req_ready !== 1'b1 || mm.mem_req_valid !== 1'b0) begin
            errors++; $display("FAIL reset_mid got rv=%b rdy=%b mv=%b want 0,1,0", rq.rsp_valid, rq.req_ready, mm.mem_req_valid);
        end
        run_op("ld_after_rst", 4'b0000, 64'h5000_0008, 64'h0, 64'h0F1E_2D3C_4B5A_6978, 0, 0, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            logic [3:0] c;
            logic [63:0] a, wd, rd;
            c  = 4'($urandom_range(0, 15));
            a  = {$urandom, $urandom};
            wd = {$urandom, $urandom};
            rd = {$urandom, $urandom};
            run_op("rand", c, a, wd, rd, $urandom_range(0, 2), $urandom_range(0, 2),
                   $urandom_range(0, 2), ($urandom_range(0, 7) == 0));
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0;
        rq.req_valid = 1'b0; rq.req_addr = '0; rq.req_wdata = '0; rq.req_ctrl = '0; rq.rsp_ready = 1'b0;
        mm.mem_req_ready = 1'b0; mm.mem_rsp_valid = 1'b0; mm.mem_rdata = '0; mm.mem_rsp_err = 1'b0;
        test_reset();
        test_store_sb();
        test_load_lw();
        test_byte_ext();
        test_backpressure();
        test_illegal_misalign();
        test_mem_err();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/lsu_unit.md
Name: lsu_unit

Overview:
- Sequential load/store unit between the execute stage and the data-memory port; it replaces the combinational, zero-latency memory access with a handshaked, multi-cycle transaction.
- Accepts one memory op per request (address, store data, 4-bit Ctrl), converts it into an 8-byte-aligned memory beat with byte strobes, and waits for the memory response.
- Returns lane-shifted, zero- or sign-extended load data to write-back through a valid/ready response channel.

Parameters:
- ADDR_W, 64, request and memory address width
- DATA_W, 64, data width; fixed at 64 (8 byte lanes)

Ports:
- clk  input  1  single clock; all state on the rising edge
- rst_n  input  1  reset, synchronous and active-low
- req_valid  input  1  execute stage presents an op
- req_ready  output  1  unit can accept an op
- req_addr  input  64  byte address
- req_wdata  input  64  store data, right-aligned
- req_ctrl  input  4  op code (see Behaviour)
- rsp_valid  output  1  result available
- rsp_ready  input  1  write-back consumes the result
- rsp_rdata  output  64  extended load data; 0 for stores and errors
- rsp_err  output  1  access fault or illegal Ctrl
- mem_req_valid  output  1  memory beat request
- mem_req_ready  input  1  memory accepts the beat
- mem_addr  output  64  {req_addr[63:3],3'b000}
- mem_wen  output  1  1 = write beat
- mem_wdata  output  64  lane-shifted store data
- mem_wstrb  output  8  byte-enable strobes
- mem_rsp_valid  input  1  memory response strobe (single cycle)
- mem_rdata  input  64  aligned 8-byte read data
- mem_rsp_err  input  1  memory fault, qualified by mem_rsp_valid

Behaviour:
- Ctrl encoding, loads:
  - 0000 LD8
  - 0001 LHU
  - 0010 LBU
  - 0011 LW (sign-extended)
  - 0100 LH (sign-extended)
  - 0101 LB (sign-extended)
  - 0110 LWU
- Ctrl encoding, stores: 1000 SD, 1001 SW, 1010 SH, 1011 SB.
- Any other Ctrl value is illegal: no memory beat; response has rsp_err=1.
- Reset values (rst_n low at a clock edge): state=IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_req_valid=0, mem_wen=0, mem_wstrb=0, mem_addr=0, mem_wdata=0.
- FSM IDLE:
  - req_ready=1.
  - On req_valid, latch addr, wdata, ctrl → REQ.
  - Illegal Ctrl (or misaligned with the optional feature) → RESP with err=1.
- FSM REQ:
  - req_ready=0, mem_req_valid=1.
  - mem_addr, mem_wen, mem_wdata and mem_wstrb stay stable until mem_req_ready.
  - On mem_req_ready → WAIT.
- FSM WAIT:
  - On mem_rsp_valid, capture the extended data (or 0 for stores) and mem_rsp_err → RESP.
- FSM RESP:
  - rsp_valid=1; rsp_rdata and rsp_err held stable.
  - On rsp_ready → IDLE.
  - No new request is accepted in the same cycle; req_ready rises the cycle after.
- Minimum latency: accept at cycle 0 → mem_req_valid at cycle 1 → mem_rsp_valid at the earliest in cycle 2 → rsp_valid at cycle 3.
- One op in flight. mem_rsp_valid outside WAIT is ignored.
- Lanes: off = addr[2:0].
  - Size mask: 8B=0xFF, 4B=0x0F, 2B=0x03, 1B=0x01.
  - mem_wstrb = mask << off; mem_wdata = wdata << (8*off).
  - Load: shifted = mem_rdata >> (8*off), then truncate to size and extend per Ctrl.
- Natural alignment violated (off not a multiple of the size), without the optional feature: the low offset bits are forced to zero (4B: off&4, 2B: off&6, 8B: off=0). No error is raised.
- mem_rsp_err=1: rsp_err=1, rsp_rdata=0.
- rst_n low mid-transaction: FSM returns to IDLE on that edge and mem_req_valid drops. A late memory response is discarded.

Optional Feature:
- MISALIGN_TRAP_EN defined:
  - A request whose address is not naturally aligned gets no memory beat.
  - FSM goes IDLE→RESP directly with rsp_err=1, rsp_rdata=0.
  - Response appears the cycle after acceptance.
- Undefined: the address is aligned down per Behaviour and the op completes normally.

Test Plan:
- SB: addr=0x80000005, wdata=0x1234_56AB, mem_req_ready=1 → mem_addr=0x80000000, mem_wstrb=0x20, mem_wdata=0x0000_AB00_0000_0000; rsp_rdata=0, rsp_err=0.
- LW: addr=0x80000004, mem_rdata=0x8000_0001_0000_0000, rsp at cycle 2 → rsp_valid at cycle 3, rsp_rdata=0xFFFF_FFFF_8000_0001.
- LBU at off=7 with mem_rdata=0xF0...: rsp_rdata=0xF0. LB on the same data: rsp_rdata=0xFFFF_FFFF_FFFF_FFF0.
- Backpressure: mem_req_ready low 3 cycles → mem_* outputs stable. rsp_ready low 2 cycles → rsp held, req_ready stays 0.
- Ctrl=1111 → no mem_req_valid; rsp_err=1. Then LH at addr=0x3:
  - MISALIGN_TRAP_EN on: err=1.
  - Off: beat at off=2, strobe 0x0C.
- rst_n low in WAIT, then mem_rsp_valid pulses → state IDLE, rsp_valid stays 0; the next LD8 completes correctly.
